synthesijer_call_driver: RTL and testbench

Hardware initiator for the req/busy method-call protocol used by compiled Synthesijer modules (`<method>_req` / `<method>_busy`). It issues a programmed number of calls to one callee method, with an incrementing argument, and captures each return value and per-call latency. A per-call watchdog detects hung callees. It sits in simulation and integration top levels wherever a method is currently kicked by a free-running comparator, and replaces that with a bounded, self-checking call sequence.

---
 rtl/synthesijer_call_driver_pkg.sv | 32 +++
 rtl/synthesijer_call_driver_if.sv | 22 ++
 rtl/synthesijer_call_driver_watchdog.sv | 44 ++++
 rtl/synthesijer_call_driver.sv | 216 +++++++++++++++++++++
 tb/tb_synthesijer_call_driver.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synthesijer_call_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synthesijer_call_pkg
//  Description : Shared constants for the Synthesijer req/busy call driver:
//                default widths, FSM state encoding and the saturating
//                increment used for latency/watchdog counting.
//  Revision    : 1.0 - initial release
// ============================================================================
package synthesijer_call_pkg;

    localparam int DEF_ARG_WIDTH = 32;
    localparam int DEF_RET_WIDTH = 32;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_TIMEOUT   = 1024;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle      = 3'd0;
    localparam logic [c_state_w-1:0] c_st_issue     = 3'd1;
    localparam logic [c_state_w-1:0] c_st_wait_ack  = 3'd2;
    localparam logic [c_state_w-1:0] c_st_wait_done = 3'd3;
    localparam logic [c_state_w-1:0] c_st_gap       = 3'd4;
    localparam logic [c_state_w-1:0] c_st_finish    = 3'd5;

    // Increment that sticks at 'limit' instead of wrapping (counters up to 32 bits).
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage : synthesijer_call_pkg
`default_nettype wire

// File: rtl/synthesijer_call_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : synthesijer_call_driver_if
//  Description : Synthesijer method-call handshake (<method>_req/_busy plus
//                argument and return value). master = caller, slave = callee.
//  Revision    : 1.0 - initial release
// ============================================================================
interface synthesijer_call_driver_if
    import synthesijer_call_pkg::*;
#(
    parameter int ARG_WIDTH = DEF_ARG_WIDTH,
    parameter int RET_WIDTH = DEF_RET_WIDTH
);
    logic                 req;
    logic [ARG_WIDTH-1:0] arg;
    logic                 busy;
    logic [RET_WIDTH-1:0] ret;

    modport master (output req, output arg, input busy, input ret);
    modport slave  (input req, input arg, output busy, output ret);
endinterface : synthesijer_call_driver_if
`default_nettype wire

// File: rtl/synthesijer_call_driver_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : call_watchdog
//  Description : Clearable saturating cycle counter. o_count is the number of
//                enabled cycles since the last clear; o_expired flags the cycle
//                on which the count is about to reach TIMEOUT, so the abort
//                decision lands on the edge where the count hits TIMEOUT.
//                CNT_WIDTH must not exceed 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module call_watchdog
    import synthesijer_call_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_clear,
    input  wire logic                 i_enable,
    output logic      [CNT_WIDTH-1:0] o_count,
    output logic                      o_expired
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;
    localparam logic [31:0]          c_max32    = 32'(c_cnt_max);
    localparam logic [31:0]          c_trip     = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    logic [CNT_WIDTH-1:0] r_count;

    // Count enabled cycles, holding at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= CNT_WIDTH'(sat_inc(32'(r_count), c_max32));
        end
    end

    assign o_count   = r_count;
    assign o_expired = (32'(r_count) >= c_trip);

endmodule : call_watchdog
`default_nettype wire

// File: rtl/synthesijer_call_driver.sv
`default_nettype none
// ============================================================================
//  Module      : synthesijer_call_driver
//  Description : Issues a programmed number of req/busy calls to one
//                Synthesijer method with an incrementing argument, capturing
//                every return value and call latency, and aborting the run
//                if a callee stays silent or busy for too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module synthesijer_call_driver
    import synthesijer_call_pkg::*;
#(
    parameter int ARG_WIDTH = DEF_ARG_WIDTH,
    parameter int RET_WIDTH = DEF_RET_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 start,
    input  wire logic [CNT_WIDTH-1:0] num_calls,
    input  wire logic [ARG_WIDTH-1:0] arg_base,
    synthesijer_call_driver_if.master call,
    output logic                      ret_valid,
    output logic      [RET_WIDTH-1:0] ret_data,
    output logic      [CNT_WIDTH-1:0] ret_index,
    output logic      [CNT_WIDTH-1:0] last_latency,
    output logic                      running,
    output logic                      done,
    output logic                      timeout_err
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;

    logic [CNT_WIDTH-1:0] r_num_calls;
    logic [ARG_WIDTH-1:0] r_arg_base;
    logic [CNT_WIDTH-1:0] r_index;

    logic                 r_ret_valid;
    logic [RET_WIDTH-1:0] r_ret_data;
    logic [CNT_WIDTH-1:0] r_ret_index;
    logic [CNT_WIDTH-1:0] r_last_latency;
    logic                 r_running;
    logic                 r_done;
    logic                 r_timeout_err;

    logic                 w_call_req;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_abort;
    logic                 w_in_call;
    logic                 w_finishing;
    logic                 w_is_last;

    logic [CNT_WIDTH-1:0] w_wd_count;
    logic                 w_wd_expired;

    // Compare with one extra bit so num_calls = all-ones cannot wrap.
    assign w_is_last = (({1'b0, r_index} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, r_num_calls});

    // The watchdog is held at 0 outside a call, so it reads 0 in the req
    // cycle and counts ISSUE/WAIT cycles: its value at busy-low is the latency.
    call_watchdog #(
        .CNT_WIDTH (CNT_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (~w_in_call),
        .i_enable  (w_in_call),
        .o_count   (w_wd_count),
        .o_expired (w_wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an expired watchdog beats a late busy rise, but a
    // completing call beats expiry.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_next_state = (num_calls == '0) ? c_st_finish : c_st_issue;
                end
            end
            c_st_issue: begin
                w_next_state = c_st_wait_ack;
            end
            c_st_wait_ack: begin
                if (w_wd_expired) begin
                    w_next_state = c_st_finish;
                end else if (call.busy) begin
                    w_next_state = c_st_wait_done;
                end
            end
            c_st_wait_done: begin
                if (!call.busy) begin
                    w_next_state = w_is_last ? c_st_finish : c_st_gap;
                end else if (w_wd_expired) begin
                    w_next_state = c_st_finish;
                end
            end
            c_st_gap: begin
                w_next_state = c_st_issue;
            end
            c_st_finish: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        w_call_req  = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_in_call   = 1'b0;
        w_finishing = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_accept = start;
            end
            c_st_issue: begin
                w_call_req = 1'b1;
                w_in_call  = 1'b1;
            end
            c_st_wait_ack: begin
                w_in_call = 1'b1;
                w_abort   = w_wd_expired;
            end
            c_st_wait_done: begin
                w_in_call = 1'b1;
                w_capture = ~call.busy;
                w_abort   = call.busy & w_wd_expired;
            end
            c_st_finish: begin
                w_finishing = 1'b1;
            end
            default: begin
                w_call_req = 1'b0;
            end
        endcase
    end

    // Run parameters, call index, capture registers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_calls    <= '0;
            r_arg_base     <= '0;
            r_index        <= '0;
            r_ret_valid    <= 1'b0;
            r_ret_data     <= '0;
            r_ret_index    <= '0;
            r_last_latency <= '0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_ret_valid <= w_capture;
            r_done      <= w_finishing;

            if (w_accept) begin
                r_num_calls   <= num_calls;
                r_arg_base    <= arg_base;
                r_index       <= '0;
                r_timeout_err <= 1'b0;
                r_running     <= 1'b1;
            end

            if (w_capture) begin
                r_ret_data     <= call.ret;
                r_ret_index    <= r_index;
                r_last_latency <= w_wd_count;
                if (!w_is_last) begin
                    r_index <= r_index + 1'b1;
                end
            end

            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end

            if (w_finishing) begin
                r_running <= 1'b0;
            end
        end
    end

    // The argument is derived from registers, so it stays put from the req
    // cycle until the index advances on completion.
    assign call.req     = w_call_req;
    assign call.arg     = r_arg_base + ARG_WIDTH'(r_index);

    assign ret_valid    = r_ret_valid;
    assign ret_data     = r_ret_data;
    assign ret_index    = r_ret_index;
    assign last_latency = r_last_latency;
    assign running      = r_running;
    assign done         = r_done;
    assign timeout_err  = r_timeout_err;

endmodule : synthesijer_call_driver
`default_nettype wire

// File: tb/tb_synthesijer_call_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_synthesijer_call_driver
//  Description : Directed bench for synthesijer_call_driver with a callee
//                model (busy for three cycles after req, ret = 2*arg, or
//                configured to hang) and a scoreboard of expected returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_synthesijer_call_driver;

    localparam int AW = 32;
    localparam int RW = 32;
    localparam int CW = 16;
    localparam int TO = 16;
    localparam int BUSY_CYCLES = 3;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [CW-1:0] idx;
        logic [CW-1:0] lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_calls = '0;
    logic [AW-1:0] arg_base = '0;
    logic          ret_valid;
    logic [RW-1:0] ret_data;
    logic [CW-1:0] ret_index;
    logic [CW-1:0] last_latency;
    logic          running;
    logic          done;
    logic          timeout_err;

    synthesijer_call_driver_if #(.ARG_WIDTH(AW), .RET_WIDTH(RW)) cif ();

    synthesijer_call_driver #(
        .ARG_WIDTH (AW),
        .RET_WIDTH (RW),
        .CNT_WIDTH (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_calls    (num_calls),
        .arg_base     (arg_base),
        .call         (cif),
        .ret_valid    (ret_valid),
        .ret_data     (ret_data),
        .ret_index    (ret_index),
        .last_latency (last_latency),
        .running      (running),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   total_reqs = 0;
    int   hang_at = -1;
    int   hang_mode = 0;
    int   callee_cnt = 0;
    logic [AW-1:0] held_arg = '0;
    logic prev_req = 1'b0;
    exp_t sb[$];
    exp_t got;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Callee model: on req, busy is seen high for BUSY_CYCLES cycles and low
    // on the next; the return value is presented as busy falls.
    initial begin
        cif.busy = 1'b0;
        cif.ret  = '0;
    end
    always @(negedge clk) begin
        if (cif.req === 1'b1) begin
            held_arg = cif.arg;
            if (total_reqs == hang_at) begin
                cif.busy   = (hang_mode != 0);
                callee_cnt = 0;
            end else begin
                cif.busy   = 1'b1;
                callee_cnt = 1;
            end
            total_reqs++;
        end else if (callee_cnt > 0) begin
            callee_cnt++;
            if (callee_cnt == BUSY_CYCLES + 2) begin
                cif.busy   = 1'b0;
                cif.ret    = held_arg * 2;
                callee_cnt = 0;
            end
        end
    end

    // Output monitor: req spacing, scoreboard pops on ret_valid, done timing.
    always @(negedge clk) begin
        if (cif.req === 1'b1) chk("req_not_back_to_back", 64'(prev_req), 64'd0);
        prev_req = cif.req;
        if (ret_valid === 1'b1) begin
            chk("ret_valid_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                chk("ret_data", 64'(ret_data), 64'(got.data));
                chk("ret_index", 64'(ret_index), 64'(got.idx));
                chk("last_latency", 64'(last_latency), 64'(got.lat));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [RW-1:0] d, input int i, input int l);
        exp_t e;
        e.data = d;
        e.idx  = CW'(i);
        e.lat  = CW'(l);
        sb.push_back(e);
    endtask

    // Drive a one-cycle start; returns at the negedge of cycle t0+1.
    task automatic do_start(input logic [CW-1:0] n, input logic [AW-1:0] base);
        start     = 1'b1;
        num_calls = n;
        arg_base  = base;
        t0        = cyc;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base_cnt;
        int i;
        base_cnt = done_cnt;
        i = 0;
        while (done_cnt == base_cnt && i < budget) begin
            tick(1);
            i++;
        end
        tick(1);
        chk({tag, "_done_in_budget"}, 64'(done_cnt != base_cnt), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 64'(cif.req), 64'd0);
        chk({tag, "_arg"}, 64'(cif.arg), 64'd0);
        chk({tag, "_ret_valid"}, 64'(ret_valid), 64'd0);
        chk({tag, "_ret_data"}, 64'(ret_data), 64'd0);
        chk({tag, "_ret_index"}, 64'(ret_index), 64'd0);
        chk({tag, "_last_latency"}, 64'(last_latency), 64'd0);
        chk({tag, "_running"}, 64'(running), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin
        int r0;
        int d0;

        // Reset state.
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // Four normal calls; stray start pulses mid-run must be ignored.
        r0 = total_reqs;
        for (int k = 0; k < 4; k++) push_exp(RW'((10 + k) * 2), k, 4);
        do_start(16'd4, 32'd10);
        chk("t1_running_c1", 64'(running), 64'd1);
        chk("t1_req_c1", 64'(cif.req), 64'd1);
        chk("t1_arg_c1", 64'(cif.arg), 64'd10);
        tick(1);
        chk("t1_req_c2", 64'(cif.req), 64'd0);
        tick(3);
        start = 1'b1; num_calls = 16'd1; arg_base = 32'd999;
        tick(1);
        start = 1'b0;
        wait_done("t1", 100);
        chk("t1_done_cycle", 64'(done_cyc), 64'(t0 + 25));
        chk("t1_timeout_err", 64'(timeout_err), 64'd0);
        chk("t1_req_count", 64'(total_reqs - r0), 64'd4);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        chk("t1_running_after", 64'(running), 64'd0);

        // Zero calls: no req, done at cycle 2, running only in cycle 1.
        r0 = total_reqs;
        do_start(16'd0, 32'd55);
        chk("t2_running_c1", 64'(running), 64'd1);
        chk("t2_done_c1", 64'(done), 64'd0);
        tick(1);
        chk("t2_done_c2", 64'(done), 64'd1);
        chk("t2_running_c2", 64'(running), 64'd0);
        tick(1);
        chk("t2_done_c3", 64'(done), 64'd0);
        chk("t2_req_count", 64'(total_reqs - r0), 64'd0);

        // Callee never raises busy: abort after TIMEOUT, no ret_valid.
        r0 = total_reqs;
        hang_mode = 0;
        hang_at = total_reqs;
        do_start(16'd3, 32'd5);
        chk("t3_req_c1", 64'(cif.req), 64'd1);
        wait_done("t3", 100);
        chk("t3_done_cycle", 64'(done_cyc), 64'(t0 + 1 + TO + 1));
        chk("t3_timeout_err", 64'(timeout_err), 64'd1);
        chk("t3_req_count", 64'(total_reqs - r0), 64'd1);

        // Callee stuck busy on call 2 of 5, then a clean rerun.
        r0 = total_reqs;
        hang_mode = 1;
        hang_at = total_reqs + 2;
        push_exp(32'd200, 0, 4);
        push_exp(32'd202, 1, 4);
        do_start(16'd5, 32'd100);
        wait_done("t4", 200);
        chk("t4_done_cycle", 64'(done_cyc), 64'(t0 + 13 + TO + 1));
        chk("t4_timeout_err", 64'(timeout_err), 64'd1);
        chk("t4_req_count", 64'(total_reqs - r0), 64'd3);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);
        hang_at = -1;
        tick(1);
        push_exp(32'd200, 0, 4);
        push_exp(32'd202, 1, 4);
        do_start(16'd2, 32'd100);
        chk("t4b_timeout_cleared", 64'(timeout_err), 64'd0);
        chk("t4b_arg_restart", 64'(cif.arg), 64'd100);
        wait_done("t4b", 100);
        chk("t4b_done_cycle", 64'(done_cyc), 64'(t0 + 13));
        chk("t4b_timeout_err", 64'(timeout_err), 64'd0);

        // Reset while waiting for busy to fall.
        do_start(16'd3, 32'd7);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk_all_zero("t5");
        reset = 1'b0;
        r0 = total_reqs;
        d0 = done_cnt;
        tick(20);
        chk("t5_no_new_req", 64'(total_reqs - r0), 64'd0);
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t5_running", 64'(running), 64'd0);

        // Argument wrap-around.
        push_exp(32'hFFFF_FFFE, 0, 4);
        push_exp(32'h0000_0000, 1, 4);
        do_start(16'd2, 32'hFFFF_FFFF);
        chk("t6_arg0", 64'(cif.arg), 64'hFFFF_FFFF);
        tick(6);
        chk("t6_req1", 64'(cif.req), 64'd1);
        chk("t6_arg1", 64'(cif.arg), 64'd0);
        wait_done("t6", 100);
        chk("t6_done_cycle", 64'(done_cyc), 64'(t0 + 13));
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed still running expected finished");
        $fatal(1, "time limit");
    end

endmodule : tb_synthesijer_call_driver
`default_nettype wire
